// File: rtl/pri_scan_64b.sv
`default_nettype none
// ============================================================================
// Module   : pri_scan_64b
// Brief    : Iterative scanner around a 64-bit priority select. It drains a
//            request bitmap one grant at a time onto a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module pri_scan_64b #(
    parameter logic        STRICT  = 1'b1,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_i,
    input  logic [63:0] data_i,
    output logic        busy_o,
    output logic        pri_init_o,
    output logic [63:0] pri_data_o,
    input  logic        pri_done_i,
    input  logic [63:0] pri_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [5:0]  out_idx_o,
    output logic [63:0] out_onehot_o,
    output logic        out_last_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_bmp;
    logic [63:0] r_grant;
    logic [5:0]  r_idx;
    logic        r_last;
    logic        r_done;
    logic        r_err;
    logic [3:0]  r_cnt;

    logic [5:0]  w_idx;
    logic        w_onehot;
    logic        w_bad;
    logic        w_cap;

    // Lowest set bit wins, so the index stays defined for a malformed grant.
    always_comb begin
        w_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (pri_data_i[i]) begin
                w_idx = 6'(i);
            end
        end
    end

    assign w_onehot = (pri_data_i != 64'd0) &&
                      ((pri_data_i & (pri_data_i - 64'd1)) == 64'd0);
    assign w_bad    = STRICT && (!w_onehot || ((pri_data_i & ~r_bmp) != 64'd0));
    assign w_cap    = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && pri_done_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_bmp   <= 64'd0;
            r_grant <= 64'd0;
            r_idx   <= 6'd0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (w_cap) begin
                r_grant <= pri_data_i;
                r_idx   <= w_idx;
                r_last  <= ((r_bmp & ~pri_data_i) == 64'd0);
                if (w_bad) begin
                    r_err   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= ST_OUT;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (init_i) begin
                            r_bmp <= data_i;
                            r_err <= 1'b0;
                            if (data_i == 64'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 4'd0;
                    end
                    ST_WAIT: begin
                        // Bitmap is kept on timeout so the stalled request is inspectable.
                        if (r_cnt == 4'(TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ST_OUT: begin
                        if (out_ready_i) begin
                            r_bmp <= r_bmp & ~r_grant;
                            if (r_last) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_REQ;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign pri_init_o   = (r_state == ST_REQ);
    assign pri_data_o   = r_bmp;
    assign out_valid_o  = (r_state == ST_OUT);
    assign out_idx_o    = out_valid_o ? r_idx   : 6'd0;
    assign out_onehot_o = out_valid_o ? r_grant : 64'd0;
    assign out_last_o   = out_valid_o & r_last;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pri_scan_64b.sv
`default_nettype none
// ============================================================================
// Module   : tb_pri_scan_64b
// Brief    : Scoreboard bench for pri_scan_64b with a behavioural priority
//            select model (combinational, registered and faulty variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pri_scan_64b;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        init_i;
    logic [63:0] data_i;
    logic        busy_o;
    logic        pri_init_o;
    logic [63:0] pri_data_o;
    logic        pri_done_i;
    logic [63:0] pri_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  out_idx_o;
    logic [63:0] out_onehot_o;
    logic        out_last_o;
    logic        done_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    bit rnd_ready = 1'b0;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    hs_q[$];
    int    done_q[$];

    bit          busy_seen = 1'b0;
    bit          stalled   = 1'b0;
    logic [63:0] held_oh;
    logic [5:0]  held_idx;
    logic        r_pd    = 1'b0;
    logic [63:0] r_pdata = 64'd0;

    pri_scan_64b #(.STRICT(1'b1), .TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .init_i       (init_i),
        .data_i       (data_i),
        .busy_o       (busy_o),
        .pri_init_o   (pri_init_o),
        .pri_data_o   (pri_data_o),
        .pri_done_i   (pri_done_i),
        .pri_data_i   (pri_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_idx_o    (out_idx_o),
        .out_onehot_o (out_onehot_o),
        .out_last_o   (out_last_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [63:0] lowest(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return 64'd1 << i;
        end
        return 64'd0;
    endfunction

    // Priority select stand-in: lowest index first.
    always @(posedge clk_i) begin
        r_pd    <= pri_init_o;
        r_pdata <= lowest(pri_data_o);
    end

    always_comb begin
        pri_done_i = 1'b0;
        pri_data_i = 64'd0;
        case (mode)
            0: begin pri_done_i = pri_init_o; pri_data_i = lowest(pri_data_o);  end
            1: begin pri_done_i = r_pd;       pri_data_i = r_pdata;             end
            2: begin pri_done_i = pri_init_o; pri_data_i = 64'h3;               end
            4: begin pri_done_i = pri_init_o; pri_data_i = lowest(~pri_data_o); end
            default: ;
        endcase
    end

    always @(posedge clk_i) begin
        if (rnd_ready) begin
            #1;
            out_ready_i = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted beat.
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_n_i === 1'b1) begin
            if (busy_o) busy_seen = 1'b1;
            if (done_o) begin
                done_q.push_back(cyc);
                chk("busy_low_at_done", 64'(busy_o), 64'd0);
            end
            if (out_valid_o) begin
                if (stalled) begin
                    chk("stall_onehot", out_onehot_o, held_oh);
                    chk("stall_idx", 64'(out_idx_o), 64'(held_idx));
                end
                if (out_ready_i) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: actual idx=%0d required=no beat", out_idx_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_idx", 64'(out_idx_o), 64'(e.idx));
                        chk("beat_onehot", out_onehot_o, 64'd1 << e.idx);
                        chk("beat_last", 64'(out_last_o), 64'(e.last));
                    end
                    hs_q.push_back(cyc);
                end else begin
                    stalled  = 1'b1;
                    held_oh  = out_onehot_o;
                    held_idx = out_idx_o;
                end
            end else begin
                stalled = 1'b0;
                chk("idle_out_zero", out_onehot_o | 64'(out_idx_o) | 64'(out_last_o), 64'd0);
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic chk_zero_outputs();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_pri_init", 64'(pri_init_o), 64'd0);
        chk("rst_pri_data", pri_data_o, 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_idx", 64'(out_idx_o), 64'd0);
        chk("rst_onehot", out_onehot_o, 64'd0);
        chk("rst_last", 64'(out_last_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
    endtask

    // Offsets are relative to the cycle in which init_i is high; 0 skips that check.
    task automatic scan(input logic [63:0] bm, input int m, input bit rnd, input bit exp_err,
                        input int first_off, input int gap, input int done_off);
        logic [63:0] rem;
        int c0;
        beat_t b;
        mode      = m;
        rnd_ready = rnd;
        exp_q.delete();
        hs_q.delete();
        done_q.delete();
        rem = exp_err ? 64'd0 : bm;
        while (rem != 64'd0) begin
            for (int i = 0; i < 64; i++) begin
                if (rem[i]) begin
                    b.idx = i;
                    break;
                end
            end
            rem[b.idx] = 1'b0;
            b.last = (rem == 64'd0);
            exp_q.push_back(b);
        end
        @(posedge clk_i);
        #2;
        if (!rnd) out_ready_i = 1'b1;
        busy_seen = 1'b0;
        init_i    = 1'b1;
        data_i    = bm;
        c0        = cyc;
        @(posedge clk_i);
        #2;
        init_i = 1'b0;
        data_i = {$urandom, $urandom};
        for (int k = 0; k < 3000 && done_q.size() == 0; k++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #2;
        chk("done_pulses", 64'(done_q.size()), 64'd1);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("err_flag", 64'(err_o), 64'(exp_err));
        if (done_q.size() > 0) begin
            if (done_off > 0) chk("done_cycle", 64'(done_q[0] - c0), 64'(done_off));
            else if (hs_q.size() > 0) chk("done_after_last", 64'(done_q[0] - hs_q[hs_q.size()-1]), 64'd1);
        end
        if (first_off > 0 && hs_q.size() > 0) chk("first_beat", 64'(hs_q[0] - c0), 64'(first_off));
        if (gap > 0) begin
            for (int i = 1; i < hs_q.size(); i++) chk("beat_gap", 64'(hs_q[i] - hs_q[i-1]), 64'(gap));
        end
        if (!exp_err) chk("bmp_final", pri_data_o, 64'd0);
        if (bm == 64'd0) chk("busy_never", 64'(busy_seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] bm;
        rst_n_i     = 1'b0;
        init_i      = 1'b0;
        data_i      = 64'd0;
        out_ready_i = 1'b0;
        #12;
        chk_zero_outputs();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;

        scan(64'h0, 0, 1'b0, 1'b0, 0, 0, 1);
        scan(64'h8000_0000_0000_0011, 0, 1'b0, 1'b0, 2, 2, 0);
        scan(64'h8000_0000_0000_0011, 1, 1'b0, 1'b0, 3, 3, 0);
        scan(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            bm = {$urandom, $urandom} & {$urandom, $urandom};
            scan(bm, $urandom_range(0, 1), 1'b1, 1'b0, 0, 0, 0);
        end

        // Malformed grants: two bits set, then a bit outside the bitmap.
        scan(64'h1, 2, 1'b0, 1'b1, 0, 0, 2);
        scan(64'h4, 0, 1'b0, 1'b0, 2, 0, 0);
        scan(64'h1, 4, 1'b0, 1'b1, 0, 0, 2);

        // Withheld grant: REQ, TO wait cycles, then the error.
        scan(64'h5, 3, 1'b0, 1'b1, 0, 0, 2 + TO);
        chk("bmp_retained", pri_data_o, 64'h5);
        scan(64'h40, 1, 1'b0, 1'b0, 3, 0, 0);

        // Asynchronous reset while a beat is stalled.
        mode      = 0;
        rnd_ready = 1'b0;
        exp_q.delete();
        @(posedge clk_i);
        #2;
        out_ready_i = 1'b0;
        init_i      = 1'b1;
        data_i      = 64'hF0;
        @(posedge clk_i);
        #2;
        init_i = 1'b0;
        for (int k = 0; k < 20 && out_valid_o !== 1'b1; k++) begin
            @(posedge clk_i);
            #2;
        end
        chk("valid_before_reset", 64'(out_valid_o), 64'd1);
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_zero_outputs();
        repeat (2) @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        scan(64'h8000_0000_0000_0001, 0, 1'b0, 1'b0, 2, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pri_scan_64b.md
# pri_scan_64b

Request-bitmap scanner placed directly upstream of `pri_64b`. It loads a 64-bit request bitmap and drives it into `pri_64b`. For each one-hot grant returned, it emits the grant and its 6-bit index on a valid/ready output port, then clears that bit and repeats until the bitmap is empty. It adds sequencing, grant checking and backpressure around the combinational priority select, so `pri_64b` can be used as an iterative arbiter or free-slot allocator.

## Interface
- `STRICT`, default 1'b1: when 1, each returned grant is checked (exactly one bit set, and that bit is set in the current bitmap); a failed check raises `err_o`.
- `TIMEOUT`, default 4: maximum cycles to wait for `pri_done_i` after the request cycle, 1..15.
- `clk_i`, in, 1: clock.
- `rst_n_i`, in, 1: asynchronous reset, active-low.
- `init_i`, in, 1: load pulse; sampled only in IDLE.
- `data_i`, in, 64: request bitmap, sampled with `init_i`.
- `busy_o`, out, 1: high in any state other than IDLE.
- `pri_init_o`, out, 1: drives `pri_64b.init_i`.
- `pri_data_o`, out, 64: drives `pri_64b.data_i`; always equals the internal bitmap `bmp_r`.
- `pri_done_i`, in, 1: from `pri_64b.done_o`.
- `pri_data_i`, in, 64: from `pri_64b.data_o`; one-hot grant.
- `out_valid_o`, out, 1: grant beat valid.
- `out_ready_i`, in, 1: consumer accepts the beat.
- `out_idx_o`, out, 6: binary index of the granted bit.
- `out_onehot_o`, out, 64: granted one-hot vector.
- `out_last_o`, out, 1: this beat empties the bitmap.
- `done_o`, out, 1: one-cycle pulse when a scan ends (normal or error).
- `err_o`, out, 1: sticky error flag; cleared when the next `init_i` is accepted.

## Operation
States:
- **IDLE**
  - On `init_i=1`: `bmp_r <= data_i` and `err_o <= 0`.
  - If `data_i==0`: stay in IDLE and pulse `done_o` next cycle. No beats are emitted.
  - Otherwise go to REQ.
- **REQ** (one cycle)
  - `pri_init_o=1`.
  - If `pri_done_i=1` in this cycle (`pri_64b` with `OUT_REG=0`), capture the grant and go to OUT.
  - Otherwise go to WAIT and clear the timeout counter.
- **WAIT**
  - `pri_init_o=0`.
  - On `pri_done_i=1`, capture the grant and go to OUT.
  - Otherwise increment the counter. When it reaches `TIMEOUT`: set `err_o`, pulse `done_o`, go to IDLE. `bmp_r` is retained.
- **Capture**
  - `grant_r <= pri_data_i`.
  - `idx_r <=` priority encode of `pri_data_i` (lowest set bit, so the index is defined even for a bad grant).
  - `last_r <= ((bmp_r & ~pri_data_i)==0)`.
  - If `STRICT` and the grant is not one-hot or `(pri_data_i & ~bmp_r)!=0`: set `err_o`, pulse `done_o`, go to IDLE. No beat is emitted.
- **OUT**
  - `out_valid_o=1`. `out_onehot_o`, `out_idx_o` and `out_last_o` are held stable until the handshake.
  - On `out_valid_o & out_ready_i`: `bmp_r <= bmp_r & ~grant_r`.
  - If `last_r`: pulse `done_o` next cycle and go to IDLE. Otherwise go to REQ.

Rules:
- `init_i` outside IDLE is ignored; there is no abort.
- `pri_done_i` outside REQ/WAIT is ignored.
- `out_*` outputs are zero whenever `out_valid_o=0`.
- `busy_o` is registered from the state.
- Priority order is whatever `pri_64b` implements; this block never reorders grants.

## Timing
- Reset values: all outputs 0, state IDLE, `bmp_r=0`, `grant_r=0`, counter 0.
- With combinational `pri_64b` and `out_ready_i=1`:
  - `init_i` accepted at cycle 0, REQ at cycle 1, first `out_valid_o` at cycle 2.
  - Beat handshake at t, REQ at t+1, next valid at t+2: throughput is one beat per 2 cycles.
- With registered `pri_64b`: one beat per 3 cycles.
- `done_o` asserts the cycle after the last handshake; `busy_o` falls in the same cycle.
- The timeout error asserts on the `TIMEOUT`-th WAIT cycle.
- Reset mid-scan: immediate return to reset values. The partially consumed bitmap is lost.

## Test plan
- Load `data_i=64'h0` -> no `out_valid_o`; `done_o` pulses exactly once, the cycle after `init_i`; `busy_o` stays 0.
- Load `64'h8000_0000_0000_0011` with `pri_64b` (`OUT_REG=0`) and `out_ready_i=1` -> 3 beats, each 2 cycles apart; indices are those of bits 0, 4 and 63 in `pri_64b` order; `out_last_o` set only on the third beat; `done_o` one cycle later.
- Same bitmap with `OUT_REG=1` -> 3 beats, each 3 cycles apart; same indices; no WAIT timeout.
- Load `64'hFFFF_FFFF_FFFF_FFFF` with `out_ready_i` toggled randomly -> 64 beats with distinct indices 0..63; outputs stable while stalled; `bmp_r` ends at 0.
- Bench-driven model returns `64'h3` for bitmap `64'h1` with `STRICT=1` -> `err_o=1`, `done_o` pulse, no beat. Next `init_i` clears `err_o`.
- Model withholds `pri_done_i` with `TIMEOUT=4` -> `err_o` after 4 WAIT cycles. Assert `rst_n_i` low mid-beat -> all outputs 0 asynchronously.
